// File: rtl/tlul_host_adapter.sv
//------------------------------------------------------------------------------
// Module  : tlul_host_adapter (with tlul_pkg)
// Brief   : Simple request/grant host port to TL-UL A/D channel adapter with
//           a bounded number of outstanding transactions and in-order
//           response checking.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tlul_pkg;
   localparam int TL_AW  = 32;
   localparam int TL_DW  = 32;
   localparam int TL_AIW = 8;
   localparam int TL_DIW = 1;
   localparam int TL_DBW = 4;
   localparam int TL_SZW = 2;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef struct packed {
      logic               a_valid;
      tl_a_op_e           a_opcode;
      logic [2:0]         a_param;
      logic [TL_SZW-1:0]  a_size;
      logic [TL_AIW-1:0]  a_source;
      logic [TL_AW-1:0]   a_address;
      logic [TL_DBW-1:0]  a_mask;
      logic [TL_DW-1:0]   a_data;
      logic               d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic               d_valid;
      tl_d_op_e           d_opcode;
      logic [2:0]         d_param;
      logic [TL_SZW-1:0]  d_size;
      logic [TL_AIW-1:0]  d_source;
      logic [TL_DIW-1:0]  d_sink;
      logic [TL_DW-1:0]   d_data;
      logic               d_error;
      logic               a_ready;
   } tl_d2h_t;
endpackage

module tlul_host_adapter #(
   parameter int MaxReqs = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_i,
   output logic              gnt_o,
   input  logic [31:0]       addr_i,
   input  logic              we_i,
   input  logic [31:0]       wdata_i,
   input  logic [3:0]        be_i,
   output logic              valid_o,
   output logic [31:0]       rdata_o,
   output logic              err_o,
   output tlul_pkg::tl_h2d_t tl_o,
   input  tlul_pkg::tl_d2h_t tl_i
);

   // Source ids live in the low 4 bits; the upper id bits stay zero so an
   // M:1 socket can shift its own tag in without clobbering ours.
   if ((MaxReqs < 1) || (MaxReqs > 16)) begin : g_bad_maxreqs
      $error("tlul_host_adapter: MaxReqs must be within 1..16");
   end

   localparam int CW  = $clog2(MaxReqs + 1);
   localparam int PW  = (MaxReqs > 1) ? $clog2(MaxReqs) : 1;
   localparam int AIW = tlul_pkg::TL_AIW;
   localparam logic [CW-1:0] c_max_cnt  = CW'(MaxReqs);
   localparam logic [PW-1:0] c_last_ptr = PW'(MaxReqs - 1);

   logic [CW-1:0] r_out_cnt;
   logic [PW-1:0] r_src_q;
   logic [PW-1:0] r_exp_q;
   logic          r_valid;
   logic [31:0]   r_rdata;
   logic          r_err;

   logic          w_a_valid;
   logic          w_a_hs;
   logic          w_d_hs;
   logic          w_d_expected;
   logic          w_unused_d;

   // A is offered only out of reset and while the outstanding window has room;
   // the registered count keeps a same-cycle D from reopening A early.
   assign w_a_valid    = req_i & rst_ni & (r_out_cnt < c_max_cnt);
   assign w_a_hs       = w_a_valid & tl_i.a_ready;
   assign w_d_hs       = tl_i.d_valid;            // d_ready is tied high
   assign w_d_expected = w_d_hs & (r_out_cnt != '0);
   assign gnt_o        = w_a_hs;

   assign w_unused_d = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink,
                         tl_i.d_source[AIW-1:4]};

   // Drive the A channel straight from the host request fields
   always_comb begin
      tl_o           = '0;
      tl_o.a_valid   = w_a_valid;
      tl_o.a_param   = 3'h0;
      tl_o.a_size    = 2'd2;
      tl_o.a_source  = AIW'(r_src_q);
      tl_o.a_address = {addr_i[31:2], 2'b00};
      tl_o.a_data    = wdata_i;
      tl_o.a_mask    = we_i ? be_i : 4'hF;
      tl_o.d_ready   = 1'b1;
      if (!we_i) begin
         tl_o.a_opcode = tlul_pkg::Get;
      end else if (be_i == 4'hF) begin
         tl_o.a_opcode = tlul_pkg::PutFullData;
      end else begin
         tl_o.a_opcode = tlul_pkg::PutPartialData;
      end
   end

   // Outstanding count: +1 on A, -1 on an expected D, unchanged on both
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_out_cnt <= '0;
      end else if (w_a_hs && !w_d_expected) begin
         r_out_cnt <= r_out_cnt + CW'(1);
      end else if (!w_a_hs && w_d_expected) begin
         r_out_cnt <= r_out_cnt - CW'(1);
      end
   end

   // Issue and expected-response pointers, each wrapping at MaxReqs
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_src_q <= '0;
         r_exp_q <= '0;
      end else begin
         if (w_a_hs) begin
            r_src_q <= (r_src_q == c_last_ptr) ? '0 : r_src_q + PW'(1);
         end
         if (w_d_expected) begin
            r_exp_q <= (r_exp_q == c_last_ptr) ? '0 : r_exp_q + PW'(1);
         end
      end
   end

   // Registered response: one-cycle valid pulse, data/error held otherwise
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_valid <= 1'b0;
         r_rdata <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= w_d_hs;
         if (w_d_hs) begin
            r_rdata <= (tl_i.d_opcode == tlul_pkg::AccessAckData) ? tl_i.d_data : 32'h0;
            r_err   <= tl_i.d_error
                     | (tl_i.d_source[3:0] != 4'(r_exp_q))
                     | (r_out_cnt == '0);
         end
      end
   end

   assign valid_o = r_valid;
   assign rdata_o = r_rdata;
   assign err_o   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_tlul_host_adapter.sv
//------------------------------------------------------------------------------
// Module  : tb_tlul_host_adapter
// Brief   : Self-checking bench for tlul_host_adapter against a queue/counter
//           reference model of the adapter's rules.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tlul_host_adapter;
   import tlul_pkg::*;

   localparam int MAXR = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_i;
   logic        gnt_o;
   logic [31:0] addr_i;
   logic        we_i;
   logic [31:0] wdata_i;
   logic [3:0]  be_i;
   logic        valid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   tl_h2d_t     tl_o;
   tl_d2h_t     tl_i;

   int total = 0;
   int bad   = 0;

   // reference model state
   int          m_cnt, m_src, m_exp;
   logic        m_valid, m_err;
   logic [31:0] m_rdata;

   always #5 clk_i = ~clk_i;

   tlul_host_adapter #(.MaxReqs(MAXR)) dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req_i   (req_i),
      .gnt_o   (gnt_o),
      .addr_i  (addr_i),
      .we_i    (we_i),
      .wdata_i (wdata_i),
      .be_i    (be_i),
      .valid_o (valid_o),
      .rdata_o (rdata_o),
      .err_o   (err_o),
      .tl_o    (tl_o),
      .tl_i    (tl_i)
   );

   // Advance one clock and update the model from the inputs held over the edge
   task automatic tick();
      bit a_hs, d_hs, d_exp;
      a_hs  = rst_ni && req_i && (m_cnt < MAXR) && tl_i.a_ready;
      d_hs  = rst_ni && tl_i.d_valid;
      d_exp = d_hs && (m_cnt > 0);
      @(posedge clk_i);
      if (!rst_ni) begin
         m_cnt = 0; m_src = 0; m_exp = 0;
         m_valid = 1'b0; m_rdata = 32'h0; m_err = 1'b0;
      end else begin
         m_valid = d_hs;
         if (d_hs) begin
            m_rdata = (tl_i.d_opcode == AccessAckData) ? tl_i.d_data : 32'h0;
            m_err   = tl_i.d_error || (int'(tl_i.d_source[3:0]) != m_exp) || (m_cnt == 0);
         end
         m_cnt = m_cnt + int'(a_hs) - int'(d_exp);
         if (d_exp) m_exp = (m_exp + 1) % MAXR;
         if (a_hs)  m_src = (m_src + 1) % MAXR;
      end
      #1;
   endtask

   task automatic idle();
      req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = 4'hF;
      tl_i = '0;
      tl_i.a_ready = 1'b1;
   endtask

   task automatic do_reset();
      idle();
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
   endtask

   task automatic send_d(input logic [7:0] src, input tl_d_op_e op,
                         input logic [31:0] data, input logic derr);
      tl_i.d_valid  = 1'b1;
      tl_i.d_source = src;
      tl_i.d_opcode = op;
      tl_i.d_data   = data;
      tl_i.d_error  = derr;
   endtask

   task automatic test_reset();
      idle();
      rst_ni = 1'b0; req_i = 1'b1;
      #1;
      total++; if (tl_o.a_valid !== 1'b0) begin bad++; $display("FAIL rst_avalid: got %b want 0", tl_o.a_valid); end
      total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL rst_gnt: got %b want 0", gnt_o); end
      tick(); tick();
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid_o); end
      total++; if (rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", rdata_o); end
      total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_o); end
      total++; if (tl_o.d_ready !== 1'b1) begin bad++; $display("FAIL rst_dready: got %b want 1", tl_o.d_ready); end
      rst_ni = 1'b1; idle();
   endtask

   task automatic test_read();
      do_reset();
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h1003;
      #1;
      total++; if (gnt_o !== 1'b1) begin bad++; $display("FAIL read_gnt: got %b want 1", gnt_o); end
      total++; if (tl_o.a_opcode !== Get) begin bad++; $display("FAIL read_op: got %0h want %0h", tl_o.a_opcode, Get); end
      total++; if (tl_o.a_address !== 32'h1000) begin bad++; $display("FAIL read_addr: got %h want 00001000", tl_o.a_address); end
      total++; if (tl_o.a_source !== 8'd0) begin bad++; $display("FAIL read_src: got %0d want 0", tl_o.a_source); end
      total++; if ({tl_o.a_mask, tl_o.a_size, tl_o.a_param} !== {4'hF, 2'd2, 3'd0}) begin
         bad++; $display("FAIL read_mask_size: got %h/%0d/%0d want f/2/0", tl_o.a_mask, tl_o.a_size, tl_o.a_param); end
      tick();
      idle();
      send_d(8'd0, AccessAckData, 32'hCAFE0001, 1'b0);
      tick();
      idle();
      total++; if ({valid_o, rdata_o, err_o} !== {1'b1, 32'hCAFE0001, 1'b0}) begin
         bad++; $display("FAIL read_resp: got v=%b d=%h e=%b want v=1 d=cafe0001 e=0", valid_o, rdata_o, err_o); end
      tick();
      total++; if ({valid_o, rdata_o} !== {1'b0, 32'hCAFE0001}) begin
         bad++; $display("FAIL read_hold: got v=%b d=%h want v=0 d=cafe0001", valid_o, rdata_o); end
   endtask

   task automatic test_write();
      do_reset();
      // host fields may change freely while no grant is given
      tl_i.a_ready = 1'b0;
      req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; wdata_i = 32'hAAAA5555;
      #1;
      total++; if (tl_o.a_opcode !== PutFullData) begin bad++; $display("FAIL wfull_op: got %0h want %0h", tl_o.a_opcode, PutFullData); end
      total++; if ({tl_o.a_valid, gnt_o} !== 2'b10) begin bad++; $display("FAIL wfull_noready: got %b%b want 10", tl_o.a_valid, gnt_o); end
      tick();
      tl_i.a_ready = 1'b1; be_i = 4'b0011; wdata_i = 32'h12345678;
      #1;
      total++; if (tl_o.a_opcode !== PutPartialData) begin bad++; $display("FAIL wpart_op: got %0h want %0h", tl_o.a_opcode, PutPartialData); end
      total++; if ({tl_o.a_mask, tl_o.a_data} !== {4'b0011, 32'h12345678}) begin
         bad++; $display("FAIL wpart_fields: got %h/%h want 3/12345678", tl_o.a_mask, tl_o.a_data); end
      total++; if (int'(tl_o.a_source) != m_src) begin bad++; $display("FAIL wpart_src: got %0d want %0d", tl_o.a_source, m_src); end
      tick();
      idle();
      send_d(8'(m_exp), AccessAck, 32'hDEADBEEF, 1'b0);
      tick();
      idle();
      total++; if ({valid_o, rdata_o, err_o} !== {1'b1, 32'h0, 1'b0}) begin
         bad++; $display("FAIL wpart_resp: got v=%b d=%h e=%b want v=1 d=0 e=0", valid_o, rdata_o, err_o); end
   endtask

   task automatic test_limit();
      logic [3:0] want_gnt;
      want_gnt = 4'b0011;
      do_reset();
      req_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (gnt_o !== want_gnt[i]) begin bad++; $display("FAIL limit_gnt%0d: got %b want %b", i, gnt_o, want_gnt[i]); end
         if (i < 2) begin
            total++; if (int'(tl_o.a_source) != i) begin bad++; $display("FAIL limit_src%0d: got %0d want %0d", i, tl_o.a_source, i); end
         end
         tick();
      end
      // a D beat at the full window must not reopen A in the same cycle
      send_d(8'd0, AccessAck, 32'h0, 1'b0);
      #1;
      total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL limit_same_cycle: got %b want 0", gnt_o); end
      tick();
      tl_i.d_valid = 1'b0;
      total++; if ({valid_o, err_o} !== 2'b10) begin bad++; $display("FAIL limit_resp: got v=%b e=%b want 1 0", valid_o, err_o); end
      #1;
      total++; if ({gnt_o, tl_o.a_source} !== {1'b1, 8'd0}) begin
         bad++; $display("FAIL limit_reopen: got gnt=%b src=%0d want gnt=1 src=0", gnt_o, tl_o.a_source); end
      tick();
      idle();
   endtask

   task automatic test_simultaneous();
      do_reset();
      req_i = 1'b1;
      tick();                                   // one outstanding, source 0
      send_d(8'd0, AccessAck, 32'h0, 1'b0);
      #1;
      total++; if ({gnt_o, tl_o.a_source} !== {1'b1, 8'd1}) begin
         bad++; $display("FAIL sim_gnt: got gnt=%b src=%0d want gnt=1 src=1", gnt_o, tl_o.a_source); end
      tick();
      tl_i.d_valid = 1'b0;
      #1;
      // count stayed at 1: exactly one more grant fits, then the window is full
      total++; if ({gnt_o, tl_o.a_source} !== {1'b1, 8'd0}) begin
         bad++; $display("FAIL sim_cnt_one: got gnt=%b src=%0d want gnt=1 src=0", gnt_o, tl_o.a_source); end
      tick();
      total++; if (gnt_o !== 1'b0) begin bad++; $display("FAIL sim_cnt_full: got %b want 0", gnt_o); end
      req_i = 1'b0;
      send_d(8'd1, AccessAck, 32'h0, 1'b0);     // exp pointer advanced to 1
      tick();
      idle();
      total++; if ({valid_o, err_o} !== 2'b10) begin bad++; $display("FAIL sim_exp_adv: got v=%b e=%b want 1 0", valid_o, err_o); end
   endtask

   task automatic test_errors();
      do_reset();
      req_i = 1'b1; tick(); req_i = 1'b0;
      send_d(8'd1, AccessAck, 32'h0, 1'b0);     // source 1 while exp is 0
      tick(); idle();
      total++; if ({valid_o, err_o} !== 2'b11) begin bad++; $display("FAIL err_source: got v=%b e=%b want 1 1", valid_o, err_o); end
      req_i = 1'b1; tick(); req_i = 1'b0;
      send_d(8'd1, AccessAckData, 32'h5A5A5A5A, 1'b1);
      tick(); idle();
      total++; if ({valid_o, err_o, rdata_o} !== {2'b11, 32'h5A5A5A5A}) begin
         bad++; $display("FAIL err_derror: got v=%b e=%b d=%h want 1 1 5a5a5a5a", valid_o, err_o, rdata_o); end
      send_d(8'd0, AccessAck, 32'h0, 1'b0);     // nothing outstanding
      tick(); idle();
      total++; if ({valid_o, err_o} !== 2'b11) begin bad++; $display("FAIL err_unexpected: got v=%b e=%b want 1 1", valid_o, err_o); end
      // window is still fully open: two grants, then full
      req_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (gnt_o !== (i < 2)) begin bad++; $display("FAIL err_no_underflow%0d: got %b want %b", i, gnt_o, (i < 2)); end
         tick();
      end
      idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_i = 1'b1; tick(); tick();             // two outstanding
      send_d(8'd0, AccessAck, 32'h0, 1'b0);
      rst_ni = 1'b0;
      #1;
      total++; if ({tl_o.a_valid, gnt_o} !== 2'b00) begin bad++; $display("FAIL rmid_gate: got %b%b want 00", tl_o.a_valid, gnt_o); end
      tick();
      rst_ni = 1'b1; tl_i.d_valid = 1'b0;
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", valid_o); end
      #1;
      total++; if ({gnt_o, tl_o.a_source} !== {1'b1, 8'd0}) begin
         bad++; $display("FAIL rmid_src: got gnt=%b src=%0d want gnt=1 src=0", gnt_o, tl_o.a_source); end
      tick();
      idle();
   endtask

   task automatic test_random();
      tl_a_op_e want_op;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         req_i   = ($urandom_range(0, 3) != 0);
         we_i    = $urandom_range(0, 1);
         addr_i  = $urandom;
         wdata_i = $urandom;
         be_i    = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
         tl_i.a_ready = ($urandom_range(0, 4) != 0);
         tl_i.d_valid = (m_cnt > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
         tl_i.d_source = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 3)) : 8'(m_exp);
         tl_i.d_opcode = ($urandom_range(0, 1) != 0) ? AccessAckData : AccessAck;
         tl_i.d_data   = $urandom;
         tl_i.d_error  = ($urandom_range(0, 15) == 0);
         #1;
         total++; if (tl_o.a_valid !== (req_i && m_cnt < MAXR)) begin
            bad++; $display("FAIL rnd_avalid@%0d: got %b want %b", i, tl_o.a_valid, (req_i && m_cnt < MAXR)); end
         total++; if (gnt_o !== (req_i && m_cnt < MAXR && tl_i.a_ready)) begin
            bad++; $display("FAIL rnd_gnt@%0d: got %b want %b", i, gnt_o, (req_i && m_cnt < MAXR && tl_i.a_ready)); end
         if (tl_o.a_valid) begin
            want_op = !we_i ? Get : (be_i == 4'hF) ? PutFullData : PutPartialData;
            total++; if ({tl_o.a_opcode, tl_o.a_address, tl_o.a_mask, tl_o.a_source}
                          !== {want_op, addr_i[31:2], 2'b00, (we_i ? be_i : 4'hF), 8'(m_src)}) begin
               bad++; $display("FAIL rnd_achan@%0d: got op=%0h a=%h m=%h s=%0d want op=%0h a=%h m=%h s=%0d", i,
                  tl_o.a_opcode, tl_o.a_address, tl_o.a_mask, tl_o.a_source,
                  want_op, {addr_i[31:2], 2'b00}, (we_i ? be_i : 4'hF), m_src); end
         end
         tick();
         total++; if ({valid_o, rdata_o, err_o} !== {m_valid, m_rdata, m_err}) begin
            bad++; $display("FAIL rnd_resp@%0d: got v=%b d=%h e=%b want v=%b d=%h e=%b", i,
               valid_o, rdata_o, err_o, m_valid, m_rdata, m_err); end
      end
      idle();
   endtask

   initial begin
      idle();
      rst_ni = 1'b0;
      m_cnt = 0; m_src = 0; m_exp = 0;
      m_valid = 1'b0; m_rdata = 32'h0; m_err = 1'b0;
      @(posedge clk_i); #1;
      test_reset();
      test_read();
      test_write();
      test_limit();
      test_simultaneous();
      test_errors();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
